// File: rtl/csa_resolver_seq.sv
// csa_resolver_seq
//   Resolves the final carry-save pair (sum row, carry row) of the 4:2
//   compressor tree into a binary product. The add is done as a chunked
//   ripple, CHUNK bits per cycle, over N = WIDTH/CHUNK cycles. One operation
//   is held at a time; valid/ready handshake on both the input and output side.
//
//   Optional feature macro: OVF_DETECT_EN
//     defined   -> extra output "ovf" = carry out of the MSB chunk, valid with
//                  out_valid, cleared on reset and when the result is consumed.
//     undefined -> no ovf port; the final carry is dropped.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   ADD   | resolving one chunk per cycle, idx 0..N-1
//   DONE  | result presented, out_valid high until out_ready

module csa_resolver_seq #(
  parameter int WIDTH = 24,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_vec,
  input  logic [WIDTH-1:0] carry_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
`ifdef OVF_DETECT_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               c_q, c_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [WIDTH-1:0]   carry_q, carry_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;

  logic [CHUNK-1:0]   sum_chunk;
  logic [CHUNK-1:0]   carry_chunk;
  logic [CHUNK:0]     chunk_sum;

  // One chunk of the ripple add: current chunks of both rows plus carry-in.
  always_comb begin
    sum_chunk   = sum_q[idx_q*CHUNK +: CHUNK];
    carry_chunk = carry_q[idx_q*CHUNK +: CHUNK];
    chunk_sum   = {1'b0, sum_chunk} + {1'b0, carry_chunk} + {{CHUNK{1'b0}}, c_q};
  end

  // Next-state and next-output logic for the IDLE/ADD/DONE sequence.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    c_d         = c_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    ovf_d       = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sum_d    = sum_vec;
          carry_d  = carry_vec;
          idx_d    = '0;
          c_d      = 1'b0;
          // Chunks not yet resolved must read as zero.
          result_d = '0;
          ovf_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_ADD;
        end
      end

      ST_ADD: begin
        result_d[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        c_d = chunk_sum[CHUNK];
        if (idx_q == LAST_IDX) begin
          // idx stays at N-1 here; it only returns to 0 on the way back to IDLE.
          ovf_d       = chunk_sum[CHUNK];
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          idx_d       = '0;
          c_d         = 1'b0;
          ovf_d       = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        idx_d       = '0;
        c_d         = 1'b0;
        ovf_d       = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      c_q         <= 1'b0;
      sum_q       <= '0;
      carry_q     <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      c_q         <= c_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  // in_ready is held low for as long as reset is asserted, and rises as soon
  // as reset releases since the state register already sits in IDLE.
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

`ifdef OVF_DETECT_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_csa_resolver_seq.sv
// Bench for csa_resolver_seq at WIDTH=24, CHUNK=4.
module tb_csa_resolver_seq;

  localparam int W = 24;
  localparam int LAT = 6;
  localparam int PERIOD_OPS = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] sum_vec;
  logic [W-1:0] carry_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         busy;
`ifdef OVF_DETECT_EN
  logic         ovf;
`endif

  csa_resolver_seq #(.WIDTH(24), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_vec   (sum_vec),
    .carry_vec (carry_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
`ifdef OVF_DETECT_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] c;
    logic [W-1:0] r;
    logic         o;
    int           stall;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: the product is simply the modular sum of both rows; the bit
  // above the top is the overflow flag.
  function automatic logic [W:0] model(input logic [W-1:0] s, input logic [W-1:0] c);
    return {1'b0, s} + {1'b0, c};
  endfunction

  task automatic check_ovf(input string nm, input logic exp);
`ifdef OVF_DETECT_EN
    chk(nm, {31'd0, ovf}, {31'd0, exp});
`endif
  endtask

  // Full operation: wait for in_ready, accept, measure latency, check result,
  // stall in DONE, then release and check the return to IDLE.
  task automatic run_op(input string nm, input logic [W-1:0] s, input logic [W-1:0] c,
                        input logic [W-1:0] er, input logic eo, input int stall);
    int n;
    logic ok;
    n = 0;
    out_ready = 1'b0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_ready"}, {31'd0, in_ready}, 32'd1);
    sum_vec   = s;
    carry_vec = c;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, n, LAT);
    chk({nm, "_res"}, {8'd0, result}, {8'd0, er});
    check_ovf({nm, "_ovf"}, eo);
    ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (result !== er || out_valid !== 1'b1) ok = 1'b0;
    end
    if (stall > 0) chk({nm, "_hold"}, {31'd0, ok}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0] m;
    logic [W-1:0] rs, rc;
    int acc_cyc[$];
    logic [W-1:0] got[$];
    int n;
    logic ok;

    vecs[0] = '{24'h00FFFF, 24'h000001, 24'h010000, 1'b0, 0};
    vecs[1] = '{24'hFFFFFF, 24'h000001, 24'h000000, 1'b1, 0};
    vecs[2] = '{24'h123456, 24'h111111, 24'h234567, 1'b0, 2};
    vecs[3] = '{24'h800000, 24'h800000, 24'h000000, 1'b1, 0};
    vecs[4] = '{24'h0F0F0F, 24'h010101, 24'h101010, 1'b0, 1};
    vecs[5] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE, 1'b1, 0};
    vecs[6] = '{24'h000000, 24'h000000, 24'h000000, 1'b0, 0};
    vecs[7] = '{24'h777777, 24'h999999, 24'h111110, 1'b1, 3};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sum_vec = '0; carry_vec = '0;
    #23;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_outs", {6'd0, out_valid, busy, result}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].c, vecs[i].r, vecs[i].o, vecs[i].stall);

    // Async reset mid-cycle while DONE.
    sum_vec = 24'h00ABCD; carry_vec = 24'h001111; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (LAT) @(negedge clk);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst", {5'd0, out_valid, in_ready, busy, result}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_rel", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Stall in DONE with new rows offered: nothing captured, then accepted later.
    sum_vec = 24'h000010; carry_vec = 24'h000020; in_valid = 1'b1;
    @(negedge clk);
    sum_vec = 24'h0A0A0A; carry_vec = 24'h050505;
    repeat (LAT) @(negedge clk);
    chk("stall_res", {8'd0, result}, 32'h000030);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (result !== 24'h000030 || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
    end
    chk("stall_hold", {31'd0, ok}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall_to_idle", {30'd0, out_valid, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("stall_new_acc", {31'd0, busy}, 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("stall_new_res", {8'd0, result}, 32'h0F0F0F);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset on the third ADD cycle aborts the operation.
    sum_vec = 24'h555555; carry_vec = 24'h222222; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("abort_no_valid", {31'd0, ok}, 32'd1);
    run_op("post_abort", 24'h123456, 24'h111111, 24'h234567, 1'b0, 0);

    // Back-to-back with in_valid held and out_ready high.
    out_ready = 1'b1;
    sum_vec = 24'h00FFFF; carry_vec = 24'h000001; in_valid = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (out_valid) got.push_back(result);
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        if (acc_cyc.size() == 1) begin
          @(negedge clk);
          sum_vec = 24'h123456; carry_vec = 24'h111111;
          continue;
        end else begin
          @(negedge clk);
          in_valid = 1'b0;
          continue;
        end
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("b2b_nacc", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) chk("b2b_gap", acc_cyc[1] - acc_cyc[0], PERIOD_OPS);
    chk("b2b_nres", got.size(), 2);
    if (got.size() == 2) begin
      chk("b2b_res0", {8'd0, got[0]}, 32'h010000);
      chk("b2b_res1", {8'd0, got[1]}, 32'h234567);
    end

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 25; i++) begin
      rs = W'($urandom);
      rc = W'($urandom);
      if (i % 5 == 0) rc = ~rs + W'($urandom_range(0, 2));
      m = model(rs, rc);
      run_op($sformatf("rnd%0d", i), rs, rc, m[W-1:0], m[W], $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
